calc_alu_seq: RTL and testbench
===============================

// Module: calc_alu_seq
// PURPOSE
//  Clocked, width-parametrised successor to the calculator's combinational ALU.
//  Accepts two unsigned operands plus a 2-bit op code on a start/done handshake.
//  ADD and SUB finish in one cycle; MUL (shift-add) and DIV (restoring) are
//  iterative, one bit per cycle. The result is registered and flagged; it sits
//  between the operand-entry logic and the calculator's display/output stage.
// PARAMETERS
//  W   4   operand width in bits (W >= 2); result width is 2*W
// PORTS
//  clk     in   1    system clock, rising edge
//  rst_n   in   1    synchronous active-low reset
//  start   in   1    request; sampled only while busy=0
//  ctrl    in   2    op: 00 ADD, 01 SUB, 10 MUL, 11 DIV
//  i1      in   W    operand A (unsigned); dividend for DIV
//  i2      in   W    operand B (unsigned); divisor for DIV
//  o       out  2*W  registered result
//  busy    out  1    high from the cycle after start is accepted until done
//  done    out  1    one-cycle pulse; o/neg/err valid and held afterwards
//  neg     out  1    SUB result negative (i1 < i2)
//  err     out  1    DIV by zero
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): o=0, busy=0, done=0, neg=0, err=0, state=IDLE.
//    Reset has priority over everything, including an operation in progress;
//    the partial result is discarded.
//  - States: IDLE -> (start & ctrl in {ADD,SUB} | DIV by 0) -> FIN;
//    IDLE -> (start & ctrl in {MUL,DIV}) -> CALC; CALC -> FIN when iter count = W;
//    FIN -> IDLE, unconditionally.
//  - Acceptance: at the edge where state=IDLE and start=1, latch ctrl/i1/i2.
//    Operand changes after acceptance have no effect.
//  - busy=1 in CALC and FIN. start while busy=1 is ignored (no queueing).
//  - done=1 exactly in the cycle after FIN is entered, i.e. concurrently with
//    the return to IDLE. Same-cycle start is accepted (back-to-back ops allowed).
//  - Latency (start edge to done high): ADD/SUB/DIV-by-0 = 2 edges; MUL/DIV = W+2 edges.
//  - ADD: o = zero-extended i1+i2 (carry lands in bit W); neg=0, err=0.
//  - SUB: o = (i1 - i2) in 2*W-bit two's complement; neg = (i1 < i2); err=0.
//  - MUL: o = i1*i2 (full 2*W bits, no truncation); neg=0, err=0.
//  - DIV: o[W-1:0] = quotient, o[2W-1:W] = remainder; neg=0, err=0.
//  - DIV with i2=0: no iteration; o = {i1, {W{1'b1}}}; err=1.
//  - o/neg/err update only at done and hold until the next done or reset.
//  - The iteration counter is $clog2(W)+1 bits wide and is cleared at acceptance.
// TESTING (W=4; latency counted in clk edges from the accepting edge)
//  1 ADD 6+2: start,ctrl=00,i1=6,i2=2 -> done after 2 edges, o=8'h08, neg=0.
//  2 SUB 2-6: ctrl=01 -> o=8'hFC, neg=1, done after 2 edges.
//  3 MUL 15*15: ctrl=10 -> busy for 5 cycles, done after 6 edges, o=8'hE1.
//  4 DIV 13/4 then 9/0: o=8'h13 (r=1,q=3) err=0; then o=8'h9F err=1 with short latency.
//  5 Reset mid-MUL: assert rst_n=0 two cycles after start -> next edge o=0,
//    busy=0; no done pulse for the aborted op.
//  6 start held high with changing operands during busy -> ignored;
//    result matches the first op; a new op is accepted in the done cycle.

Source files
------------

// File: rtl/calc_alu_seq.sv
// Sequential calculator ALU: ADD/SUB in one step, MUL (shift-add) and DIV
// (restoring) one bit per cycle, on a start/done handshake with a registered result.
module calc_alu_seq #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     ctrl,
  input  logic [W-1:0]   i1,
  input  logic [W-1:0]   i2,
  output logic [2*W-1:0] o,
  output logic           busy,
  output logic           done,
  output logic           neg,
  output logic           err,
  output logic [1:0]     o_dbg_state
);

  // Handshake: an op is accepted at a rising edge where start=1 and the unit
  // is idle (busy=0); done pulses for one cycle when o/neg/err become valid,
  // and that cycle is idle again so a new start can be accepted in it.

  localparam int CW = $clog2(W) + 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_ctrl;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [2*W-1:0]   r_work;
  logic [CW-1:0]    r_cnt;
  logic [2*W-1:0]   r_o;
  logic             r_neg;
  logic             r_err;
  logic             r_done;

  logic             w_accept;
  logic             w_div0;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_busy;

  logic [W:0]       w_mul_sum;
  logic [2*W-1:0]   w_mul_nxt;
  logic [2*W:0]     w_div_sh;
  logic [W:0]       w_div_hi;
  logic [W:0]       w_div_diff;
  logic             w_div_ge;
  logic [2*W-1:0]   w_div_nxt;

  logic [2*W-1:0]   w_res;
  logic             w_res_neg;
  logic             w_res_err;

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_div0    = (ctrl == OP_DIV) && (i2 == '0);
  assign w_cnt_inc = r_cnt + 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and FSM outputs
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (ctrl[1] && !w_div0) w_state_nxt = S_CALC;
          else                    w_state_nxt = S_FIN;
        end
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (w_cnt_inc == CW'(W)) w_state_nxt = S_FIN;
      end
      S_FIN: begin
        w_busy      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift-add step: low half holds the remaining multiplier bits, high half
  // the running partial product; the whole pair shifts right each cycle.
  always_comb begin
    w_mul_sum = {1'b0, r_work[2*W-1:W]} + (r_work[0] ? {1'b0, r_a} : {(W+1){1'b0}});
    w_mul_nxt = {w_mul_sum, r_work[W-1:1]};
  end

  // Restoring-division step: high half is the remainder, low half shifts the
  // dividend out and the quotient bits in.
  always_comb begin
    w_div_sh   = {r_work, 1'b0};
    w_div_hi   = w_div_sh[2*W:W];
    w_div_ge   = (w_div_hi >= {1'b0, r_b});
    w_div_diff = w_div_hi - {1'b0, r_b};
    if (w_div_ge) w_div_nxt = {w_div_diff[W-1:0], w_div_sh[W-1:1], 1'b1};
    else          w_div_nxt = w_div_sh[2*W-1:0];
  end

  // Final result selection, consumed only in FIN
  always_comb begin
    w_res     = r_work;
    w_res_neg = 1'b0;
    w_res_err = 1'b0;
    case (r_ctrl)
      OP_ADD: w_res = {{W{1'b0}}, r_a} + {{W{1'b0}}, r_b};
      OP_SUB: begin
        w_res     = {{W{1'b0}}, r_a} - {{W{1'b0}}, r_b};
        w_res_neg = (r_a < r_b);
      end
      OP_MUL: w_res = r_work;
      OP_DIV: begin
        if (r_b == '0) begin
          w_res     = {r_a, {W{1'b1}}};
          w_res_err = 1'b1;
        end else begin
          w_res = r_work;
        end
      end
      default: w_res = r_work;
    endcase
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_work <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_ctrl <= ctrl;
      r_a    <= i1;
      r_b    <= i2;
      r_cnt  <= '0;
      if (ctrl == OP_MUL) r_work <= {{W{1'b0}}, i2};
      else                r_work <= {{W{1'b0}}, i1};
    end else if (r_state == S_CALC) begin
      r_cnt <= w_cnt_inc;
      if (r_ctrl == OP_MUL) r_work <= w_mul_nxt;
      else                  r_work <= w_div_nxt;
    end
  end

  // Visible results change only when leaving FIN, together with done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_o    <= '0;
      r_neg  <= 1'b0;
      r_err  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIN);
      if (r_state == S_FIN) begin
        r_o   <= w_res;
        r_neg <= w_res_neg;
        r_err <= w_res_err;
      end
    end
  end

  assign o           = r_o;
  assign neg         = r_neg;
  assign err         = r_err;
  assign done        = r_done;
  assign busy        = w_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_calc_alu_seq.sv
// Bench for calc_alu_seq (W=4): directed vector table, multi-cycle corner
// sequences, and randomized ops checked against an arithmetic reference model.
module tb_calc_alu_seq;

  localparam int W  = 4;
  localparam int OW = 2 * W;
  localparam int EW = OW + 10;   // {latency[7:0], err, neg, o}

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [1:0]    ctrl;
  logic [W-1:0]  i1;
  logic [W-1:0]  i2;
  logic [OW-1:0] o;
  logic          busy;
  logic          done;
  logic          neg;
  logic          err;
  logic [1:0]    dbg_state;

  calc_alu_seq #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ctrl        (ctrl),
    .i1          (i1),
    .i2          (i2),
    .o           (o),
    .busy        (busy),
    .done        (done),
    .neg         (neg),
    .err         (err),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic [1:0]    c;
    int            a;
    int            b;
    logic [OW-1:0] o;
    logic          neg;
    logic          err;
    int            lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation's definition
  function automatic logic [EW-1:0] model(input logic [1:0] c, input int a, input int b);
    int r;
    int lat;
    logic ng;
    logic er;
    ng  = 1'b0;
    er  = 1'b0;
    lat = W + 2;
    r   = 0;
    case (c)
      2'd0: begin r = a + b; lat = 2; end
      2'd1: begin r = (a - b) & ((1 << OW) - 1); ng = (a < b); lat = 2; end
      2'd2: r = a * b;
      default: begin
        if (b == 0) begin
          r = (a << W) | ((1 << W) - 1); er = 1'b1; lat = 2;
        end else begin
          r = ((a % b) << W) | (a / b);
        end
      end
    endcase
    return {8'(lat), er, ng, OW'(r)};
  endfunction

  // Driver: issue one op in an idle cycle, wait (bounded) for done, score it
  task automatic run_op(input logic [1:0] c, input int a, input int b,
                        input logic [EW-1:0] exp, input string name);
    int edges;
    logic [EW-1:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    ctrl  = c;
    i1    = W'(a);
    i2    = W'(b);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 1;
    check({name, ".busy"}, {31'd0, busy}, 32'd1);
    while (!done && edges < 64) begin
      @(posedge clk);
      #1;
      edges++;
    end
    e = exp_q.pop_front();
    check({name, ".lat"}, edges, {24'd0, e[EW-1:EW-8]});
    check({name, ".o"},   {24'd0, o}, {24'd0, e[OW-1:0]});
    check({name, ".neg"}, {31'd0, neg}, {31'd0, e[OW]});
    check({name, ".err"}, {31'd0, err}, {31'd0, e[OW+1]});
  endtask

  function automatic logic [EW-1:0] pack_vec(input vec_t v);
    return {8'(v.lat), v.err, v.neg, v.o};
  endfunction

  initial begin
    int pulses;
    logic [1:0] rc;
    int ra;
    int rb;

    vecs.push_back('{2'd0,  6,  2, 8'h08, 1'b0, 1'b0, 2});
    vecs.push_back('{2'd1,  2,  6, 8'hFC, 1'b1, 1'b0, 2});
    vecs.push_back('{2'd2, 15, 15, 8'hE1, 1'b0, 1'b0, 6});
    vecs.push_back('{2'd3, 13,  4, 8'h13, 1'b0, 1'b0, 6});
    vecs.push_back('{2'd3,  9,  0, 8'h9F, 1'b0, 1'b1, 2});
    vecs.push_back('{2'd0, 15, 15, 8'h1E, 1'b0, 1'b0, 2});
    vecs.push_back('{2'd1, 15,  0, 8'h0F, 1'b0, 1'b0, 2});
    vecs.push_back('{2'd1,  0, 15, 8'hF1, 1'b1, 1'b0, 2});
    vecs.push_back('{2'd2,  0,  7, 8'h00, 1'b0, 1'b0, 6});
    vecs.push_back('{2'd2, 15,  1, 8'h0F, 1'b0, 1'b0, 6});
    vecs.push_back('{2'd3,  3,  7, 8'h30, 1'b0, 1'b0, 6});
    vecs.push_back('{2'd3, 15, 15, 8'h01, 1'b0, 1'b0, 6});
    vecs.push_back('{2'd3,  0,  0, 8'h0F, 1'b0, 1'b1, 2});
    vecs.push_back('{2'd3, 15,  1, 8'h0F, 1'b0, 1'b0, 6});

    rst_n = 1'b0;
    start = 1'b0;
    ctrl  = 2'd0;
    i1    = '0;
    i2    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.o",     {24'd0, o}, 32'd0);
    check("rst.busy",  {31'd0, busy}, 32'd0);
    check("rst.done",  {31'd0, done}, 32'd0);
    check("rst.neg",   {31'd0, neg}, 32'd0);
    check("rst.err",   {31'd0, err}, 32'd0);
    check("rst.state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;

    // Directed vectors
    foreach (vecs[k]) run_op(vecs[k].c, vecs[k].a, vecs[k].b, pack_vec(vecs[k]), $sformatf("vec%0d", k));

    // Results hold after done while idle
    repeat (3) @(posedge clk);
    #1;
    check("hold.o",    {24'd0, o}, 32'h0F);
    check("hold.done", {31'd0, done}, 32'd0);
    check("hold.busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a multiply discards it
    @(negedge clk);
    ctrl = 2'd2; i1 = 4'd15; i2 = 4'd15; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rstmul.o",    {24'd0, o}, 32'd0);
    check("rstmul.busy", {31'd0, busy}, 32'd0);
    check("rstmul.done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("rstmul.nodone", pulses, 32'd0);

    // start held high with scrambled operands while busy, then back-to-back op
    @(negedge clk);
    ctrl = 2'd2; i1 = 4'd5; i2 = 4'd3; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < W + 1; k++) begin
      @(negedge clk);
      ctrl = 2'($urandom_range(0, 3));
      i1   = W'($urandom_range(0, 15));
      i2   = W'($urandom_range(0, 15));
      @(posedge clk);
    end
    #1;
    check("held.done", {31'd0, done}, 32'd1);
    check("held.o",    {24'd0, o}, 32'h0F);
    @(negedge clk);
    ctrl = 2'd0; i1 = 4'd1; i2 = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b.busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("b2b.done", {31'd0, done}, 32'd1);
    check("b2b.o",    {24'd0, o}, 32'h02);

    // Randomized ops against the reference model
    for (int k = 0; k < 300; k++) begin
      rc = 2'($urandom_range(0, 3));
      ra = int'($urandom_range(0, 15));
      rb = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 15));
      run_op(rc, ra, rb, model(rc, ra, rb), $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
